// File: rtl/nv_nvdla_apb2csb_pkg.sv
// Shared types and constants for the APB-to-CSB bridge.
// Holds the bridge FSM state encoding, the CSB data width and the write-strobe legality helper.
package nv_nvdla_apb2csb_pkg;

  localparam int CSB_DW = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RD,
    WAIT_WR,
    RESP
  } state_e;

  // Partial-word writes cannot be expressed on CSB, so only full-strobe writes are legal.
  function automatic logic strb_ok(input logic write, input logic [3:0] strb);
    return !write || (strb == 4'hF);
  endfunction

endpackage

// File: rtl/nv_nvdla_apb2csb_tmo.sv
// Response-wait watchdog: expire is high in the TIMEOUT-th enabled cycle after clr.
// Combinational expire, no backpressure; TIMEOUT=0 never expires.
module nv_nvdla_apb2csb_tmo #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic pclk,
  input  logic prst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge pclk) begin
    if (prst || clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (TIMEOUT != 0) && en && (cnt == TLAST);

endmodule

// File: rtl/nv_nvdla_apb2csb_np.sv
// APB slave to NVDLA CSB bridge, one transaction outstanding.
// pready 1/2/3+ cycles after ACCESS (error/posted write/read or non-posted); CSB valid held until ready.
module nv_nvdla_apb2csb_np
  import nv_nvdla_apb2csb_pkg::*;
#(
  parameter int              AW         = 32,
  parameter int              CSB_AW     = 16,
  parameter bit              NPOSTED_WR = 1'b0,
  parameter int unsigned     TIMEOUT    = 255,
  parameter logic [AW-1:0]   ADDR_BASE  = '0,
  parameter logic [AW-1:0]   ADDR_MASK  = '0
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [AW-1:0]     paddr,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              csb2nvdla_valid,
  input  logic              csb2nvdla_ready,
  output logic [CSB_AW-1:0] csb2nvdla_addr,
  output logic [31:0]       csb2nvdla_wdat,
  output logic              csb2nvdla_write,
  output logic              csb2nvdla_nposted,
  input  logic              nvdla2csb_valid,
  input  logic [31:0]       nvdla2csb_data,
  input  logic              nvdla2csb_wr_complete,
  output logic              tmo_pulse
);

  state_e              state_q, state_d;
  logic [CSB_AW-1:0]   addr_q;
  logic [CSB_DW-1:0]   wdat_q;
  logic                write_q;
  logic                valid_q, pready_q, pslverr_q, tmo_q;
  logic [CSB_DW-1:0]   prdata_q, prdata_d;
  logic                err_d, tmo_d;
  logic                legal, accept;
  logic                tmo_clr, tmo_en, tmo_expire;

  assign legal  = (paddr[1:0] == 2'b00)
                  && ((paddr & ADDR_MASK) == ADDR_BASE)
                  && strb_ok(pwrite, pstrb);
  assign accept = (state_q == IDLE) && psel && penable;
  assign tmo_en = (state_q == WAIT_RD) || (state_q == WAIT_WR);

  nv_nvdla_apb2csb_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .pclk   (pclk),
    .prst   (prst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = 1'b0;
    tmo_d    = 1'b0;
    prdata_d = '0;
    tmo_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (psel && penable) begin
          if (legal) begin
            state_d = REQ;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      REQ: begin
        if (csb2nvdla_ready) begin
          if (!write_q) begin
            state_d = WAIT_RD;
            tmo_clr = 1'b1;
          end else if (NPOSTED_WR) begin
            state_d = WAIT_WR;
            tmo_clr = 1'b1;
          end else begin
            state_d = RESP;
          end
        end
      end
      // A response arriving in the expiry cycle still counts as a good completion.
      WAIT_RD: begin
        if (nvdla2csb_valid) begin
          state_d  = RESP;
          prdata_d = nvdla2csb_data;
        end else if (tmo_expire) begin
          state_d = RESP;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      WAIT_WR: begin
        if (nvdla2csb_wr_complete) begin
          state_d = RESP;
        end else if (tmo_expire) begin
          state_d = RESP;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdat_q    <= '0;
      write_q   <= 1'b0;
      valid_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && legal) begin
        addr_q  <= paddr[CSB_AW+1:2];
        wdat_q  <= pwdata;
        write_q <= pwrite;
      end
      valid_q   <= (state_d == REQ);
      pready_q  <= (state_d == RESP);
      pslverr_q <= err_d;
      prdata_q  <= prdata_d;
      tmo_q     <= tmo_d;
    end
  end

  assign prdata            = prdata_q;
  assign pready            = pready_q;
  assign pslverr           = pslverr_q;
  assign csb2nvdla_valid   = valid_q;
  assign csb2nvdla_addr    = addr_q;
  assign csb2nvdla_wdat    = wdat_q;
  assign csb2nvdla_write   = write_q;
  assign csb2nvdla_nposted = NPOSTED_WR;
  assign tmo_pulse         = tmo_q;

endmodule

// File: tb/tb_nv_nvdla_apb2csb_np.sv
// Directed bench: a posted bridge (decode window 0x0000_xxxx) and a non-posted bridge with TIMEOUT=4.
// APB psel is steered to one instance at a time; CSB-side stimulus is shared.
module tb_nv_nvdla_apb2csb_np;

  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = 4'hF;
  logic        use_np = 1'b0;
  logic        csb_ready = 1'b0, rsp_valid = 1'b0, wr_complete = 1'b0;
  logic [31:0] rsp_data = '0;

  always #5 pclk = ~pclk;

  logic [31:0] a_prdata, b_prdata, a_wdat, b_wdat;
  logic [15:0] a_addr, b_addr;
  logic        a_pready, a_pslverr, a_valid, a_write, a_np, a_tmo;
  logic        b_pready, b_pslverr, b_valid, b_write, b_np, b_tmo;

  nv_nvdla_apb2csb_np #(
    .NPOSTED_WR (1'b0), .TIMEOUT (255),
    .ADDR_BASE (32'h0000_0000), .ADDR_MASK (32'hFFFF_0000)
  ) dut (
    .pclk (pclk), .prst (prst), .psel (psel && !use_np), .penable (penable), .pwrite (pwrite),
    .paddr (paddr), .pwdata (pwdata), .pstrb (pstrb), .prdata (a_prdata), .pready (a_pready),
    .pslverr (a_pslverr), .csb2nvdla_valid (a_valid), .csb2nvdla_ready (csb_ready),
    .csb2nvdla_addr (a_addr), .csb2nvdla_wdat (a_wdat), .csb2nvdla_write (a_write),
    .csb2nvdla_nposted (a_np), .nvdla2csb_valid (rsp_valid), .nvdla2csb_data (rsp_data),
    .nvdla2csb_wr_complete (wr_complete), .tmo_pulse (a_tmo)
  );

  nv_nvdla_apb2csb_np #(
    .NPOSTED_WR (1'b1), .TIMEOUT (4)
  ) dut_np (
    .pclk (pclk), .prst (prst), .psel (psel && use_np), .penable (penable), .pwrite (pwrite),
    .paddr (paddr), .pwdata (pwdata), .pstrb (pstrb), .prdata (b_prdata), .pready (b_pready),
    .pslverr (b_pslverr), .csb2nvdla_valid (b_valid), .csb2nvdla_ready (csb_ready),
    .csb2nvdla_addr (b_addr), .csb2nvdla_wdat (b_wdat), .csb2nvdla_write (b_write),
    .csb2nvdla_nposted (b_np), .nvdla2csb_valid (rsp_valid), .nvdla2csb_data (rsp_data),
    .nvdla2csb_wr_complete (wr_complete), .tmo_pulse (b_tmo)
  );

  wire        m_pready  = use_np ? b_pready  : a_pready;
  wire        m_pslverr = use_np ? b_pslverr : a_pslverr;
  wire [31:0] m_prdata  = use_np ? b_prdata  : a_prdata;
  wire        m_valid   = use_np ? b_valid   : a_valid;
  wire [15:0] m_addr    = use_np ? b_addr    : a_addr;
  wire [31:0] m_wdat    = use_np ? b_wdat    : a_wdat;
  wire        m_write   = use_np ? b_write   : a_write;
  wire        m_tmo     = use_np ? b_tmo     : a_tmo;

  int checks = 0;
  int errors = 0;

  // CSB-side monitor: valid cycles, request stability while valid, timeout pulses.
  int          vld_cnt = 0, unstable = 0, tmo_cnt = 0;
  logic [15:0] cap_addr = '0;
  logic [31:0] cap_wdat = '0;
  logic        cap_write = 1'b0;

  always @(negedge pclk) begin
    if (m_valid) begin
      if (vld_cnt > 0 && (m_addr !== cap_addr || m_wdat !== cap_wdat || m_write !== cap_write))
        unstable++;
      vld_cnt++;
      cap_addr  = m_addr;
      cap_wdat  = m_wdat;
      cap_write = m_write;
    end
    if (m_tmo) tmo_cnt++;
  end

  int          x_lat;
  logic [31:0] x_rd;
  logic        x_err, x_after;

  task automatic clr_mon();
    vld_cnt = 0; unstable = 0; tmo_cnt = 0;
  endtask

  // APB master: latency counted in cycles from the ACCESS cycle to the pready cycle.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    bit done = 1'b0;
    x_lat = -1; x_rd = 'x; x_err = 1'bx; x_after = 1'bx;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(negedge pclk);
    penable = 1'b1;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge pclk);
      if (m_pready) begin
        done = 1'b1; x_lat = i; x_rd = m_prdata; x_err = m_pslverr;
      end
    end
    @(negedge pclk);
    x_after = m_pready;
    psel = 1'b0; penable = 1'b0;
  endtask

  // CSB target: ready rdy_dly cycles after valid, then optional response rsp_dly cycles later.
  task automatic csb_slave(input int rdy_dly, input bit rsp, input int rsp_dly, input bit wrc,
                           input logic [31:0] d);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge pclk);
      seen = m_valid;
    end
    if (seen) begin
      repeat (rdy_dly) @(negedge pclk);
      csb_ready = 1'b1;
      @(negedge pclk);
      csb_ready = 1'b0;
      if (rsp) begin
        repeat (rsp_dly) @(negedge pclk);
        if (wrc) wr_complete = 1'b1;
        else begin rsp_valid = 1'b1; rsp_data = d; end
        @(negedge pclk);
        wr_complete = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
      end
    end
  endtask

  task automatic test_reset();
    prst = 1'b1;
    repeat (3) @(negedge pclk);
    prst = 1'b0;
    @(negedge pclk);
    checks++; if ({a_pready, a_pslverr, a_prdata, a_valid, a_addr, a_wdat, a_write, a_tmo} !== '0) begin errors++; $display("FAIL reset_a outputs got %h want 0", {a_pready, a_pslverr, a_prdata, a_valid, a_addr, a_wdat, a_write, a_tmo}); end
    checks++; if ({b_pready, b_pslverr, b_prdata, b_valid, b_addr, b_wdat, b_write, b_tmo} !== '0) begin errors++; $display("FAIL reset_b outputs got %h want 0", {b_pready, b_pslverr, b_prdata, b_valid, b_addr, b_wdat, b_write, b_tmo}); end
    checks++; if (a_np !== 1'b0) begin errors++; $display("FAIL reset_nposted_a got %b want 0", a_np); end
    checks++; if (b_np !== 1'b1) begin errors++; $display("FAIL reset_nposted_b got %b want 1", b_np); end
  endtask

  task automatic test_posted_write();
    use_np = 1'b0; clr_mon();
    fork
      apb_xfer(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
      csb_slave(0, 1'b0, 0, 1'b0, 32'h0);
    join
    checks++; if (x_lat !== 2) begin errors++; $display("FAIL pw_latency got %0d want 2", x_lat); end
    checks++; if (x_err !== 1'b0 || x_rd !== 32'h0) begin errors++; $display("FAIL pw_resp got err=%b rd=%h want err=0 rd=0", x_err, x_rd); end
    checks++; if (cap_addr !== 16'h0401) begin errors++; $display("FAIL pw_addr got %h want 0401", cap_addr); end
    checks++; if (cap_wdat !== 32'hDEAD_BEEF || cap_write !== 1'b1) begin errors++; $display("FAIL pw_wdat got %h/%b want deadbeef/1", cap_wdat, cap_write); end
    checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL pw_valid_cycles got %0d want 1", vld_cnt); end
    checks++; if (x_after !== 1'b0) begin errors++; $display("FAIL pw_pready_width got %b want 0", x_after); end
  endtask

  task automatic test_read_delayed();
    use_np = 1'b0; clr_mon();
    fork
      apb_xfer(1'b0, 32'h0000_0008, 32'h0, 4'hF);
      csb_slave(3, 1'b1, 0, 1'b0, 32'h1234_5678);
    join
    checks++; if (x_lat !== 6) begin errors++; $display("FAIL rd_latency got %0d want 6", x_lat); end
    checks++; if (x_rd !== 32'h1234_5678 || x_err !== 1'b0) begin errors++; $display("FAIL rd_data got %h err=%b want 12345678 err=0", x_rd, x_err); end
    checks++; if (vld_cnt !== 4 || unstable !== 0) begin errors++; $display("FAIL rd_valid_hold got %0d unstable=%0d want 4 unstable=0", vld_cnt, unstable); end
    checks++; if (cap_addr !== 16'h0002 || cap_write !== 1'b0) begin errors++; $display("FAIL rd_req got %h/%b want 0002/0", cap_addr, cap_write); end
  endtask

  task automatic test_illegal();
    logic [31:0] addrs [3] = '{32'h0000_0002, 32'h0000_0010, 32'h0001_0000};
    logic        wrs   [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0]  strbs [3] = '{4'hF, 4'h3, 4'hF};
    use_np = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clr_mon();
      apb_xfer(wrs[k], addrs[k], 32'hFFFF_FFFF, strbs[k]);
      checks++; if (x_lat !== 1 || x_err !== 1'b1 || x_rd !== 32'h0) begin errors++; $display("FAIL illegal_%0d got lat=%0d err=%b rd=%h want 1/1/0", k, x_lat, x_err, x_rd); end
      checks++; if (vld_cnt !== 0) begin errors++; $display("FAIL illegal_%0d_csb got %0d valid cycles want 0", k, vld_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    use_np = 1'b0; clr_mon();
    fork
      apb_xfer(1'b0, 32'h0000_0040, 32'h0, 4'hF);
      csb_slave(0, 1'b1, 0, 1'b0, 32'hA5A5_0001);
    join
    checks++; if (x_lat !== 3 || x_rd !== 32'hA5A5_0001 || x_err !== 1'b0) begin errors++; $display("FAIL b2b_read got lat=%0d rd=%h err=%b want 3/a5a50001/0", x_lat, x_rd, x_err); end
    clr_mon();
    fork
      apb_xfer(1'b1, 32'h0000_0010, 32'h0BAD_F00D, 4'hF);
      csb_slave(0, 1'b0, 0, 1'b0, 32'h0);
    join
    checks++; if (x_lat !== 2 || cap_addr !== 16'h0004 || cap_wdat !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_write got lat=%0d addr=%h wdat=%h want 2/0004/0badf00d", x_lat, cap_addr, cap_wdat); end
  endtask

  task automatic test_reset_mid();
    use_np = 1'b0; clr_mon();
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0008; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    csb_ready = 1'b1;
    @(negedge pclk);
    // Bridge is in WAIT_RD; a response coincides with reset and must be lost.
    csb_ready = 1'b0; psel = 1'b0; penable = 1'b0;
    prst = 1'b1; rsp_valid = 1'b1; rsp_data = 32'hFFFF_FFFF;
    @(negedge pclk);
    prst = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    checks++; if ({a_pready, a_pslverr, a_prdata, a_valid, a_addr, a_wdat, a_write, a_tmo, a_np} !== '0) begin errors++; $display("FAIL rst_mid outputs got %h want 0", {a_pready, a_pslverr, a_prdata, a_valid, a_addr, a_wdat, a_write, a_tmo, a_np}); end
    clr_mon();
    fork
      apb_xfer(1'b0, 32'h0000_000C, 32'h0, 4'hF);
      csb_slave(0, 1'b1, 0, 1'b0, 32'h600D_0003);
    join
    checks++; if (x_lat !== 3 || x_rd !== 32'h600D_0003 || x_err !== 1'b0) begin errors++; $display("FAIL rst_mid_next got lat=%0d rd=%h err=%b want 3/600d0003/0", x_lat, x_rd, x_err); end
  endtask

  task automatic test_np_timeout();
    int stray = 0;
    use_np = 1'b1; clr_mon();
    fork
      apb_xfer(1'b1, 32'h0000_0020, 32'h1111_2222, 4'hF);
      csb_slave(0, 1'b0, 0, 1'b1, 32'h0);
    join
    checks++; if (x_lat !== 6) begin errors++; $display("FAIL tmo_latency got %0d want 6", x_lat); end
    checks++; if (x_err !== 1'b1 || x_rd !== 32'h0) begin errors++; $display("FAIL tmo_resp got err=%b rd=%h want 1/0", x_err, x_rd); end
    checks++; if (tmo_cnt !== 1) begin errors++; $display("FAIL tmo_pulse got %0d cycles want 1", tmo_cnt); end
    wr_complete = 1'b1;
    @(negedge pclk);
    wr_complete = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      if (m_pready || m_valid || m_tmo) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL tmo_late_rsp got %0d active cycles want 0", stray); end
    clr_mon();
    fork
      apb_xfer(1'b1, 32'h0000_0024, 32'h3333_4444, 4'hF);
      csb_slave(0, 1'b1, 0, 1'b1, 32'h0);
    join
    checks++; if (x_lat !== 3 || x_err !== 1'b0 || tmo_cnt !== 0) begin errors++; $display("FAIL np_write got lat=%0d err=%b tmo=%0d want 3/0/0", x_lat, x_err, tmo_cnt); end
  endtask

  task automatic test_np_race();
    use_np = 1'b1; clr_mon();
    fork
      apb_xfer(1'b1, 32'h0000_0028, 32'h5555_6666, 4'hF);
      csb_slave(0, 1'b1, 3, 1'b1, 32'h0);
    join
    checks++; if (x_lat !== 6 || x_err !== 1'b0 || tmo_cnt !== 0) begin errors++; $display("FAIL race got lat=%0d err=%b tmo=%0d want 6/0/0", x_lat, x_err, tmo_cnt); end
    use_np = 1'b0;
  endtask

  initial begin
    test_reset();
    test_posted_write();
    test_read_delayed();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_np_timeout();
    test_np_race();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
